store_drain_unit: RTL and testbench
===================================

Name: store_drain_unit

Overview:
Receives committed stores that the store queue releases at retirement and buffers them in an in-order FIFO. Drains them one at a time to the data cache write port through a valid/ready request and a done response. Once the cache confirms the write, it returns a one-cycle completion packet carrying store_pos to the store queue, which then frees the slot. It sits between the store queue retire output and the dcache write port.

Parameters:
N_WAY, 2, max stores accepted per cycle.
SB_DEPTH, 8, FIFO entries (power of 2, >= N_WAY).
N_SQ, 8, store-queue size; sets pos width PW = $clog2(N_SQ)+1.

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
ret_valid  in  N_WAY  per-lane retired-store valid; lanes packed from lane 0
ret_addr  in  N_WAY x 32  byte address
ret_data  in  N_WAY x 32  store data, right-justified
ret_size  in  N_WAY x 2  BYTE=0, HALF=1, WORD=2
ret_pos  in  N_WAY x PW  store_pos (1-based SQ slot)
free_slots  out  $clog2(SB_DEPTH)+1  empty FIFO entries (ROB caps store retirement with this)
dc_wr_valid  out  1  write request
dc_wr_addr  out  32  8-byte-aligned block address (addr[31:3], low bits 0)
dc_wr_data  out  64  data shifted to byte lane
dc_wr_be  out  8  byte enables
dc_wr_ready  in  1  cache accepts request this cycle
dc_wr_done  in  1  write complete (1-cycle pulse)
done_valid  out  1  completion to SQ
done_pos  out  PW  store_pos of completed store
misalign  out  1  1-cycle pulse; current drained store is misaligned

Behaviour:
- Reset: FIFO empty, head = tail = 0, free_slots = SB_DEPTH, state IDLE. All outputs are 0 except free_slots.
- Enqueue: each cycle, lanes with ret_valid are written at tail in lane order, and tail advances by the valid count (mod SB_DEPTH).
- Valid lanes are contiguous from lane 0. Upstream never exceeds free_slots. If it does, the excess lanes are dropped and a simulation assertion fires.
- free_slots is registered. It reflects the FIFO occupancy after this cycle's enqueue and dequeue.
- FSM IDLE: if the FIFO is non-empty (registered count > 0), latch the head entry into the request regs and go to REQ. An entry enqueued at cycle T drives dc_wr_valid no earlier than T+1.
- FSM REQ: hold dc_wr_valid = 1 with addr, data and be stable until dc_wr_ready. On the ready cycle, drop valid and go to WAIT.
- FSM WAIT: wait for dc_wr_done. On done, pop the head and go to DONE. A done that arrives in the same cycle as ready is legal: go straight to DONE.
- FSM DONE: done_valid = 1 and done_pos = entry pos for exactly 1 cycle, then IDLE. Maximum throughput is one store per 3 cycles, and at most one completion per cycle.
- Lane formatting, with off = addr[2:0]:
  - BYTE: be = 1 << off, data = data[7:0] << 8*off.
  - HALF: be = 2'b11 << off.
  - WORD: be = 4'hF << off.
  - Data bits above the size are masked to 0 before shifting.
- Misalignment: HALF with off[0] != 0, or WORD with off[1:0] != 0. In that case force off to align down, pulse misalign in the REQ-entry cycle, and still complete normally.
- Simultaneous enqueue and dequeue in one cycle: count changes by (enq - deq). A full FIFO with a pop admits one new entry the same cycle.
- Pointer wrap-around is handled modulo SB_DEPTH. Count is kept as a separate register to tell full from empty.
- Branch hazard and flush do not affect this block, because all contents are committed.
- Reset mid-transaction returns to IDLE immediately, discards the FIFO, and suppresses any pending done. A dc_wr_done arriving in IDLE or REQ is ignored.

Decomposition:
- The shared package (sys_defs) holds:
  - MEM_SIZE enum (BYTE/HALF/WORD);
  - the STORE_PACKET_RET struct {valid, address, data, size, store_pos}, reused for the ret_* ports;
  - a STORE_DONE_PACKET struct {valid, store_pos} matching what the SQ consumes;
  - `N_WAY, `N_SQ, and the new `SB_DEPTH.
- One sub-module: store_lane_fmt, a combinational size/offset to {be, data64, misalign} formatter.

Test Plan:
- Reset, then one WORD store addr=0x1004, data=0xDEADBEEF, pos=3 at T0 -> dc_wr_valid at T1 with addr 0x1000, be=0xF0, data=0xDEADBEEF_00000000. With ready at T1 and done at T3 -> done_valid with pos=3 at T4, and free_slots returns to 8.
- Same cycle, lane0 BYTE 0x2003 data 0x1AB pos 1 and lane1 HALF 0x2006 data 0x12345 pos 2 -> first request be=0x08, data byte3=0xAB; second request be=0xC0, data[63:48]=0x2345. Completions arrive in order 1 then 2, and free_slots reads 6 after the enqueue.
- Fill 8 entries with ready held low -> free_slots=0 and dc_wr_valid with addr stable across 5 stall cycles. When ready rises and the entry pops while 1 new store enqueues in the same cycle -> free_slots stays 0 and no entry is lost.
- HALF at 0x3001 -> misalign pulses for 1 cycle, be=0x03, and the store completes with done_valid.
- dc_wr_ready and dc_wr_done in the same cycle -> DONE next cycle with a single done pulse. A spurious dc_wr_done in IDLE -> no done_valid.
- Reset asserted while in WAIT with 3 entries queued -> next cycle: no done_valid, free_slots=8, dc_wr_valid=0.

Source files
------------

// File: rtl/store_drain_unit_pkg.sv
// rtl/store_drain_unit_pkg.sv - shared store packet types and sizing for the store drain unit
package store_drain_unit_pkg;

  localparam int N_WAY    = 2;
  localparam int SB_DEPTH = 8;
  localparam int N_SQ     = 8;
  localparam int PW       = $clog2(N_SQ) + 1;
  localparam int CW       = $clog2(SB_DEPTH) + 1;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MEM_SIZE;

  typedef struct packed {
    logic            valid;
    logic [31:0]     address;
    logic [31:0]     data;
    MEM_SIZE         size;
    logic [PW-1:0]   store_pos;
  } STORE_PACKET_RET;

  typedef struct packed {
    logic            valid;
    logic [PW-1:0]   store_pos;
  } STORE_DONE_PACKET;

endpackage

// File: rtl/store_drain_unit_if.sv
// rtl/store_drain_unit_if.sv - dcache write port between the drain unit and the cache
interface store_drain_unit_if;

  logic        dc_wr_valid;
  logic [31:0] dc_wr_addr;
  logic [63:0] dc_wr_data;
  logic [7:0]  dc_wr_be;
  logic        dc_wr_ready;
  logic        dc_wr_done;

  modport master (
    output dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
    input  dc_wr_ready, dc_wr_done
  );

  modport slave (
    input  dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
    output dc_wr_ready, dc_wr_done
  );

endinterface

// File: rtl/store_lane_fmt.sv
// rtl/store_lane_fmt.sv - places a sized store into its 8-byte block lane
module store_lane_fmt
  import store_drain_unit_pkg::*;
(
  input  MEM_SIZE     size,
  input  logic [2:0]  addr_off,
  input  logic [31:0] data,
  output logic [7:0]  be,
  output logic [63:0] data64,
  output logic        misalign
);

  logic [2:0]  off;
  logic [3:0]  be_raw;
  logic [31:0] masked;

  // Misaligned halves/words are pulled down to their natural boundary
  always_comb begin
    off      = addr_off;
    be_raw   = 4'h1;
    masked   = {24'b0, data[7:0]};
    misalign = 1'b0;
    case (size)
      HALF: begin
        be_raw   = 4'h3;
        masked   = {16'b0, data[15:0]};
        misalign = addr_off[0];
        off      = {addr_off[2:1], 1'b0};
      end
      WORD: begin
        be_raw   = 4'hF;
        masked   = data;
        misalign = |addr_off[1:0];
        off      = {addr_off[2], 2'b00};
      end
      default: ;
    endcase
    be     = {4'b0, be_raw} << off;
    data64 = {32'b0, masked} << {off, 3'b000};
  end

endmodule

// File: rtl/store_drain_unit.sv
// rtl/store_drain_unit.sv - buffers retired stores and drains them one at a time to the dcache
module store_drain_unit
  import store_drain_unit_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          ret_valid,
  input  logic [N_WAY-1:0][31:0]    ret_addr,
  input  logic [N_WAY-1:0][31:0]    ret_data,
  input  logic [N_WAY-1:0][1:0]     ret_size,
  input  logic [N_WAY-1:0][PW-1:0]  ret_pos,
  output logic [CW-1:0]             free_slots,
  store_drain_unit_if.master        dc,
  output logic                      done_valid,
  output logic [PW-1:0]             done_pos,
  output logic                      misalign
);

  localparam int IW = $clog2(SB_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  STORE_PACKET_RET  fifo [SB_DEPTH];
  logic [IW-1:0]    head, tail;
  logic [CW-1:0]    count, room, n_valid, n_enq;
  logic             deq;
  logic [1:0]       state;
  logic [PW-1:0]    cur_pos;
  logic [31:0]      wr_addr;
  logic [63:0]      wr_data;
  logic [7:0]       wr_be;
  logic [7:0]       fmt_be;
  logic [63:0]      fmt_data;
  logic             fmt_mis;
  STORE_DONE_PACKET done_pkt;

  store_lane_fmt u_fmt (
    .size     (fifo[head].size),
    .addr_off (fifo[head].address[2:0]),
    .data     (fifo[head].data),
    .be       (fmt_be),
    .data64   (fmt_data),
    .misalign (fmt_mis)
  );

  // A pop in the same cycle frees one slot for this cycle's enqueue
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < N_WAY; i++) begin
      n_valid = n_valid + CW'(ret_valid[i]);
    end
    deq   = dc.dc_wr_done && ((state == S_WAIT) || (state == S_REQ && dc.dc_wr_ready));
    room  = CW'(SB_DEPTH) - count + CW'(deq);
    n_enq = (n_valid > room) ? room : n_valid;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (CW'(i) < n_enq) begin
        fifo[tail + IW'(i)] <= '{valid: 1'b1, address: ret_addr[i], data: ret_data[i],
                                 size: MEM_SIZE'(ret_size[i]), store_pos: ret_pos[i]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      state    <= S_IDLE;
      cur_pos  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_be    <= '0;
      misalign <= 1'b0;
    end else begin
      tail     <= tail + IW'(n_enq);
      head     <= head + IW'(deq);
      count    <= count + n_enq - CW'(deq);
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0 && fifo[head].valid) begin
            wr_addr  <= {fifo[head].address[31:3], 3'b000};
            wr_data  <= fmt_data;
            wr_be    <= fmt_be;
            misalign <= fmt_mis;
            cur_pos  <= fifo[head].store_pos;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (dc.dc_wr_ready) state <= dc.dc_wr_done ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (dc.dc_wr_done) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    done_pkt = '0;
    if (state == S_DONE) begin
      done_pkt.valid     = 1'b1;
      done_pkt.store_pos = cur_pos;
    end
  end

  assign free_slots     = CW'(SB_DEPTH) - count;
  assign dc.dc_wr_valid = (state == S_REQ);
  assign dc.dc_wr_addr  = wr_addr;
  assign dc.dc_wr_data  = wr_data;
  assign dc.dc_wr_be    = wr_be;
  assign done_valid     = done_pkt.valid;
  assign done_pos       = done_pkt.store_pos;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset) n_valid <= room);
  a_lanes_packed: assert property (@(posedge clock) disable iff (reset)
    (ret_valid & (ret_valid + N_WAY'(1))) == '0);

endmodule

// File: tb/tb_store_drain_unit.sv
// tb/tb_store_drain_unit.sv - self-checking bench for store_drain_unit
module tb_store_drain_unit;
  import store_drain_unit_pkg::*;

  logic                      clock;
  logic                      reset;
  logic [N_WAY-1:0]          ret_valid;
  logic [N_WAY-1:0][31:0]    ret_addr;
  logic [N_WAY-1:0][31:0]    ret_data;
  logic [N_WAY-1:0][1:0]     ret_size;
  logic [N_WAY-1:0][PW-1:0]  ret_pos;
  logic [CW-1:0]             free_slots;
  logic                      done_valid;
  logic [PW-1:0]             done_pos;
  logic                      misalign;

  store_drain_unit_if dc ();

  store_drain_unit dut (
    .clock      (clock),
    .reset      (reset),
    .ret_valid  (ret_valid),
    .ret_addr   (ret_addr),
    .ret_data   (ret_data),
    .ret_size   (ret_size),
    .ret_pos    (ret_pos),
    .free_slots (free_slots),
    .dc         (dc),
    .done_valid (done_valid),
    .done_pos   (done_pos),
    .misalign   (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          rdly;
    int          ddly;
    logic [31:0] ea;
    logic [7:0]  ebe;
    logic [63:0] ed;
    logic        em;
  } vec_t;

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [1:0]    size;
    logic [PW-1:0] pos;
  } st_t;

  vec_t vecs [8];

  // Reference formatting from the size/offset rules using plain arithmetic
  task automatic model_fmt(input st_t e, output logic [31:0] a, output logic [7:0] be,
                           output logic [63:0] d, output logic m);
    int          nbytes;
    int          off;
    logic [63:0] mask;
    nbytes = 1 << e.size;
    off    = int'(e.addr % 8);
    m      = (off % nbytes) != 0;
    off    = off - (off % nbytes);
    a      = e.addr - (e.addr % 8);
    be     = 8'(((1 << nbytes) - 1) << off);
    mask   = (64'd1 << (8 * nbytes)) - 64'd1;
    d      = ({32'b0, e.data} & mask) << (8 * off);
  endtask

  task automatic put_lane(input int l, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [PW-1:0] p);
    ret_valid[l] = 1'b1;
    ret_addr[l]  = a;
    ret_data[l]  = d;
    ret_size[l]  = s;
    ret_pos[l]   = p;
  endtask

  // Called at a negedge; waits for the request, checks it, then completes it
  task automatic serve(input logic [31:0] ea, input logic [7:0] ebe, input logic [63:0] ed,
                       input logic em, input logic [PW-1:0] ep, input int rdly, input int ddly);
    int n;
    n = 0;
    while (!dc.dc_wr_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("req_valid", 64'(dc.dc_wr_valid), 64'd1);
    chk("req_addr", 64'(dc.dc_wr_addr), 64'(ea));
    chk("req_be", 64'(dc.dc_wr_be), 64'(ebe));
    chk("req_data", dc.dc_wr_data, ed);
    chk("req_misalign", 64'(misalign), 64'(em));
    for (int k = 0; k < rdly; k++) begin
      @(negedge clock);
      chk("stall_valid", 64'(dc.dc_wr_valid), 64'd1);
      chk("stall_addr", 64'(dc.dc_wr_addr), 64'(ea));
      chk("stall_misalign", 64'(misalign), 64'd0);
    end
    dc.dc_wr_ready = 1'b1;
    dc.dc_wr_done  = (ddly == 0);
    @(negedge clock);
    dc.dc_wr_ready = 1'b0;
    dc.dc_wr_done  = 1'b0;
    chk("valid_drop", 64'(dc.dc_wr_valid), 64'd0);
    if (ddly > 0) begin
      chk("early_done", 64'(done_valid), 64'd0);
      for (int k = 1; k < ddly; k++) begin
        @(negedge clock);
        chk("wait_no_done", 64'(done_valid), 64'd0);
      end
      dc.dc_wr_done = 1'b1;
      @(negedge clock);
      dc.dc_wr_done = 1'b0;
    end
    chk("done_valid", 64'(done_valid), 64'd1);
    chk("done_pos", 64'(done_pos), 64'(ep));
    @(negedge clock);
    chk("done_single", 64'(done_valid), 64'd0);
  endtask

  st_t           pend [$];
  logic [PW-1:0] cpl  [$];

  initial begin
    st_t           e;
    logic [31:0]   ea, open_addr;
    logic [7:0]    ebe;
    logic [63:0]   ed;
    logic          em;
    int            occ, nmax, nl, n;
    bit            req_open, await_done, stall;
    st_t           fill [9];

    vecs[0] = '{32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 0, 2, 32'h1000, 8'hF0, 64'hDEADBEEF_00000000, 1'b0};
    vecs[1] = '{32'h0000_2003, 32'h0000_01AB, 2'd0, 0, 1, 32'h2000, 8'h08, 64'h00000000_AB000000, 1'b0};
    vecs[2] = '{32'h0000_2006, 32'h0001_2345, 2'd1, 1, 0, 32'h2000, 8'hC0, 64'h23450000_00000000, 1'b0};
    vecs[3] = '{32'h0000_3001, 32'h0000_BEEF, 2'd1, 1, 1, 32'h3000, 8'h03, 64'h00000000_0000BEEF, 1'b1};
    vecs[4] = '{32'h0000_4003, 32'hCAFE_F00D, 2'd2, 0, 0, 32'h4000, 8'h0F, 64'h00000000_CAFEF00D, 1'b1};
    vecs[5] = '{32'h0000_5007, 32'hFFFF_FF5A, 2'd0, 2, 3, 32'h5000, 8'h80, 64'h5A000000_00000000, 1'b0};
    vecs[6] = '{32'h0000_600E, 32'h1122_3344, 2'd2, 0, 1, 32'h6008, 8'hF0, 64'h11223344_00000000, 1'b1};
    vecs[7] = '{32'h0000_7FFC, 32'hFFFF_8001, 2'd1, 3, 0, 32'h7FF8, 8'h30, 64'h00008001_00000000, 1'b0};

    reset = 1'b1;
    ret_valid = '0; ret_addr = '0; ret_data = '0; ret_size = '0; ret_pos = '0;
    dc.dc_wr_ready = 1'b0;
    dc.dc_wr_done  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_free", 64'(free_slots), 64'd8);
    chk("rst_valid", 64'(dc.dc_wr_valid), 64'd0);
    chk("rst_done", 64'(done_valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_free", 64'(free_slots), 64'd8);
    chk("idle_addr", 64'(dc.dc_wr_addr), 64'd0);
    chk("idle_be", 64'(dc.dc_wr_be), 64'd0);
    chk("idle_data", dc.dc_wr_data, 64'd0);
    chk("idle_misalign", 64'(misalign), 64'd0);
    chk("idle_done_pos", 64'(done_pos), 64'd0);

    // Table of single stores through the whole path
    for (int i = 0; i < 8; i++) begin
      put_lane(0, vecs[i].addr, vecs[i].data, vecs[i].size, PW'(i + 1));
      @(negedge clock);
      ret_valid = '0;
      chk("vec_free_enq", 64'(free_slots), 64'd7);
      serve(vecs[i].ea, vecs[i].ebe, vecs[i].ed, vecs[i].em, PW'(i + 1), vecs[i].rdly, vecs[i].ddly);
      chk("vec_free_after", 64'(free_slots), 64'd8);
    end

    // Two lanes in one cycle complete in lane order
    put_lane(0, 32'h2003, 32'h1AB, 2'd0, PW'(1));
    put_lane(1, 32'h2006, 32'h12345, 2'd1, PW'(2));
    @(negedge clock);
    ret_valid = '0;
    chk("dual_free", 64'(free_slots), 64'd6);
    serve(32'h2000, 8'h08, 64'h00000000_AB000000, 1'b0, PW'(1), 0, 1);
    serve(32'h2000, 8'hC0, 64'h23450000_00000000, 1'b0, PW'(2), 1, 0);
    chk("dual_free_end", 64'(free_slots), 64'd8);

    // Fill to full with the cache stalled, then pop and enqueue together
    for (int k = 0; k < 9; k++) begin
      fill[k] = '{32'h0001_0004 + 32'(k * 8), 32'hA5A5_0000 + 32'(k), 2'd2, PW'(k + 1)};
    end
    for (int c = 0; c < 4; c++) begin
      put_lane(0, fill[2*c].addr, fill[2*c].data, fill[2*c].size, fill[2*c].pos);
      put_lane(1, fill[2*c+1].addr, fill[2*c+1].data, fill[2*c+1].size, fill[2*c+1].pos);
      @(negedge clock);
      chk("fill_free", 64'(free_slots), 64'(8 - 2 * (c + 1)));
    end
    ret_valid = '0;
    chk("full_valid", 64'(dc.dc_wr_valid), 64'd1);
    chk("full_addr", 64'(dc.dc_wr_addr), 64'h10000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("full_stall_addr", 64'(dc.dc_wr_addr), 64'h10000);
      chk("full_stall_free", 64'(free_slots), 64'd0);
    end
    dc.dc_wr_ready = 1'b1;
    dc.dc_wr_done  = 1'b1;
    put_lane(0, fill[8].addr, fill[8].data, fill[8].size, fill[8].pos);
    @(negedge clock);
    dc.dc_wr_ready = 1'b0;
    dc.dc_wr_done  = 1'b0;
    ret_valid = '0;
    chk("full_swap_free", 64'(free_slots), 64'd0);
    chk("full_swap_done", 64'(done_valid), 64'd1);
    chk("full_swap_pos", 64'(done_pos), 64'(fill[0].pos));
    for (int k = 1; k < 9; k++) begin
      serve(32'h0001_0000 + 32'(k * 8), 8'hF0, {fill[k].data, 32'h0}, 1'b0, fill[k].pos, 0, 0);
    end
    chk("full_free_end", 64'(free_slots), 64'd8);

    // Done in IDLE must be ignored
    dc.dc_wr_done = 1'b1;
    @(negedge clock);
    dc.dc_wr_done = 1'b0;
    chk("spur_done", 64'(done_valid), 64'd0);
    chk("spur_free", 64'(free_slots), 64'd8);
    @(negedge clock);
    chk("spur_done2", 64'(done_valid), 64'd0);

    // Reset while waiting for done with entries queued
    put_lane(0, 32'h8000, 32'h1, 2'd2, PW'(1));
    put_lane(1, 32'h8008, 32'h2, 2'd2, PW'(2));
    @(negedge clock);
    ret_valid = 2'b01;
    ret_addr[0] = 32'h8010; ret_pos[0] = PW'(3);
    @(negedge clock);
    ret_valid = '0;
    n = 0;
    while (!dc.dc_wr_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rstw_req", 64'(dc.dc_wr_valid), 64'd1);
    dc.dc_wr_ready = 1'b1;
    @(negedge clock);
    dc.dc_wr_ready = 1'b0;
    reset = 1'b1;
    dc.dc_wr_done = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    dc.dc_wr_done = 1'b0;
    chk("rstw_done", 64'(done_valid), 64'd0);
    chk("rstw_free", 64'(free_slots), 64'd8);
    chk("rstw_valid", 64'(dc.dc_wr_valid), 64'd0);
    repeat (3) @(negedge clock);
    chk("rstw_quiet_valid", 64'(dc.dc_wr_valid), 64'd0);
    chk("rstw_quiet_done", 64'(done_valid), 64'd0);

    // Randomized traffic against a queue-based reference
    occ = 0; req_open = 0; await_done = 0; open_addr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_free", 64'(free_slots), 64'(8 - occ));
      if (dc.dc_wr_valid && !req_open) begin
        if (pend.size() == 0) begin
          chk("rnd_req_unexpected", 64'd1, 64'd0);
          ea = dc.dc_wr_addr;
        end else begin
          e = pend.pop_front();
          model_fmt(e, ea, ebe, ed, em);
          chk("rnd_addr", 64'(dc.dc_wr_addr), 64'(ea));
          chk("rnd_be", 64'(dc.dc_wr_be), 64'(ebe));
          chk("rnd_data", dc.dc_wr_data, ed);
          chk("rnd_misalign", 64'(misalign), 64'(em));
          cpl.push_back(e.pos);
        end
        req_open = 1;
        open_addr = ea;
      end else begin
        chk("rnd_misalign_quiet", 64'(misalign), 64'd0);
        if (req_open) chk("rnd_addr_stable", 64'(dc.dc_wr_addr), 64'(open_addr));
      end
      if (done_valid) begin
        if (cpl.size() == 0) chk("rnd_done_unexpected", 64'd1, 64'd0);
        else chk("rnd_done_pos", 64'(done_pos), 64'(cpl.pop_front()));
      end
      if (cyc >= 3000 && occ == 0 && pend.size() == 0 && cpl.size() == 0 && !req_open && !await_done)
        break;

      stall = (cyc % 200) < 40;
      dc.dc_wr_ready = 1'b0;
      dc.dc_wr_done  = 1'b0;
      nmax = (8 - occ < N_WAY) ? 8 - occ : N_WAY;
      if (req_open && !stall && $urandom_range(0, 2) == 0) begin
        dc.dc_wr_ready = 1'b1;
        req_open = 0;
        if ($urandom_range(0, 1) == 1) begin
          dc.dc_wr_done = 1'b1;
          occ--;
        end else begin
          await_done = 1;
        end
      end else if (await_done && $urandom_range(0, 2) == 0) begin
        dc.dc_wr_done = 1'b1;
        await_done = 0;
        occ--;
      end else if (!await_done && $urandom_range(0, 9) == 0) begin
        dc.dc_wr_done = 1'b1;
      end

      ret_valid = '0;
      if (cyc < 3000) begin
        nl = $urandom_range(0, nmax);
        for (int l = 0; l < nl; l++) begin
          e = '{$urandom, $urandom, 2'($urandom_range(0, 2)), PW'($urandom_range(1, 8))};
          put_lane(l, e.addr, e.data, e.size, e.pos);
          pend.push_back(e);
        end
        occ += nl;
      end
      @(negedge clock);
    end
    dc.dc_wr_ready = 1'b0;
    dc.dc_wr_done  = 1'b0;
    ret_valid = '0;
    chk("rnd_drained", 64'(occ + pend.size() + cpl.size()), 64'd0);
    chk("rnd_end_free", 64'(free_slots), 64'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
